loc_pair_dedup: RTL and testbench

LOC_PAIR_DEDUP -- requirements
Module: loc_pair_dedup

---
 rtl/loc_pair_dedup.sv | 165 ++++++++++++++++
 tb/tb_loc_pair_dedup.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/loc_pair_dedup.sv
`default_nettype none
// ============================================================================
// Module      : loc_pair_dedup
// Description : Assembles 32-bit location half-words (low, then high) into
//               64-bit records, drops back-to-back duplicate records, and
//               buffers the result in a first-word-fall-through FIFO. The
//               all-ones record marks end of stream and is flagged on out_last.
// Revision    : 1.0 - initial release
// ============================================================================
module loc_pair_dedup #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [63:0]       out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [CNT_W-1:0]  rec_cnt,
    output logic [CNT_W-1:0]  dup_cnt
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [1:0]  S_LO      = 2'd0;
    localparam logic [1:0]  S_HI      = 2'd1;
    localparam logic [1:0]  S_DONE    = 2'd2;
    localparam logic [63:0] C_MARKER  = {64{1'b1}};
    localparam logic [AW:0] C_FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_OCC_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]     r_state;
    logic [1:0]     w_state_nxt;
    logic [31:0]    r_low;
    logic [63:0]    r_last;
    logic           r_last_vld;
    logic           r_alive;
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_occ;
    logic [64:0]    r_mem [DEPTH];
    logic [CNT_W-1:0] r_rec;
    logic [CNT_W-1:0] r_dup;

    logic [64:0]    w_head;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_fire;
    logic           w_hi_fire;
    logic [63:0]    w_rec;
    logic           w_is_marker;
    logic           w_is_dup;
    logic           w_push;
    logic           w_drop;

    // FIFO head drives the output directly; zeroed whenever nothing is held
    assign w_head    = r_mem[r_rptr];
    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == C_FULL);
    assign out_valid = !w_empty;
    assign out       = out_valid ? w_head[63:0] : 64'd0;
    assign out_last  = out_valid & w_head[64];
    assign w_pop     = out_valid & out_ready;

    assign w_fire      = in_valid & in_ready;
    assign w_hi_fire   = w_fire & (r_state == S_HI);
    assign w_rec       = {in, r_low};
    assign w_is_marker = (w_rec == C_MARKER);
    assign w_is_dup    = r_last_vld & (w_rec == r_last);
    assign w_push      = w_hi_fire & (w_is_marker | !w_is_dup);
    assign w_drop      = w_hi_fire & !w_is_marker & w_is_dup;

    assign rec_cnt = r_rec;
    assign dup_cnt = r_dup;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_LO;
        else      r_state <= w_state_nxt;
    end

    // Next-state: DONE holds until the end marker itself leaves the FIFO
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LO:    if (w_fire) w_state_nxt = S_HI;
            S_HI:    if (w_fire) w_state_nxt = w_is_marker ? S_DONE : S_LO;
            S_DONE:  if (w_pop && w_head[64]) w_state_nxt = S_LO;
            default: w_state_nxt = S_LO;
        endcase
    end

    // Ready: a full FIFO still accepts the high half if the head pops this cycle
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            S_LO:    in_ready = r_alive;
            S_HI:    in_ready = !w_full | w_pop;
            default: in_ready = 1'b0;
        endcase
    end

    // Low-half latch, last-record tracking and post-reset ready enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_low      <= '0;
            r_last     <= '0;
            r_last_vld <= 1'b0;
            r_alive    <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_fire && r_state == S_LO) r_low <= in;
            if (w_hi_fire) begin
                if (w_is_marker) begin
                    r_last_vld <= 1'b0;
                end else if (w_push) begin
                    r_last     <= w_rec;
                    r_last_vld <= 1'b1;
                end
            end
        end
    end

    // FIFO pointers and occupancy; push+pop together leaves occupancy alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + C_PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + C_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + C_OCC_ONE;
                2'b01:   r_occ <= r_occ - C_OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FIFO storage: record plus last flag; contents are masked while empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {w_is_marker, w_rec};
    end

    // Saturating statistics; the end marker is not counted as a record
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rec <= '0;
            r_dup <= '0;
        end else begin
            if (w_push && !w_is_marker && r_rec != C_CNT_MAX) r_rec <= r_rec + C_CNT_ONE;
            if (w_drop && r_dup != C_CNT_MAX)                 r_dup <= r_dup + C_CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_loc_pair_dedup.sv
`default_nettype none
// ============================================================================
// Module      : tb_loc_pair_dedup
// Description : Self-checking bench for loc_pair_dedup: table of records with
//               expected counters, scoreboard of expected output records, and
//               hand sequences for backpressure, end of stream, reset and
//               counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_loc_pair_dedup;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_in;
    logic        d_in_valid;
    logic        d_in_ready;
    logic [63:0] d_out;
    logic        d_out_valid;
    logic        d_out_ready;
    logic        d_out_last;
    logic [15:0] d_rec;
    logic [15:0] d_dup;

    logic [31:0] s_in;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [63:0] s_out;
    logic        s_out_valid;
    logic        s_out_last;
    logic [3:0]  s_rec;
    logic [3:0]  s_dup;

    int total = 0;
    int bad   = 0;
    int vcnt  = 0;

    logic [64:0] sb_q[$];
    logic [63:0] m_last;
    bit          m_lastv = 0;
    int          m_rec   = 0;
    int          m_dup   = 0;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          exp_rec;
        int          exp_dup;
    } vec_t;
    vec_t vt[9];

    always #5 clk = ~clk;

    loc_pair_dedup #(.DEPTH(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in(d_in), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .out(d_out), .out_valid(d_out_valid), .out_ready(d_out_ready), .out_last(d_out_last),
        .rec_cnt(d_rec), .dup_cnt(d_dup)
    );

    loc_pair_dedup #(.DEPTH(8), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in(s_in), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .out(s_out), .out_valid(s_out_valid), .out_ready(1'b1), .out_last(s_out_last),
        .rec_cnt(s_rec), .dup_cnt(s_dup)
    );

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Output monitor: a transfer happens at the next rising edge
    always @(negedge clk) begin
        if (rst && d_out_valid) begin
            vcnt++;
            if (d_out_ready) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got %h expected nothing", {d_out_last, d_out});
                end else begin
                    check("sb_record", {d_out_last, d_out}, sb_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [31:0] w);
        int t = 0;
        d_in       = w;
        d_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (d_in_ready) break;
            t++;
            if (t > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 word=%h", w);
                break;
            end
        end
        @(posedge clk);
        #1;
        d_in_valid = 1'b0;
    endtask

    task automatic model_push(input logic [31:0] lo, input logic [31:0] hi);
        logic [63:0] r;
        r = {hi, lo};
        if (r == {64{1'b1}}) begin
            sb_q.push_back({1'b1, r});
            m_lastv = 0;
        end else if (m_lastv && r == m_last) begin
            m_dup++;
        end else begin
            sb_q.push_back({1'b0, r});
            m_last  = r;
            m_lastv = 1;
            m_rec++;
        end
    endtask

    task automatic send_rec(input logic [31:0] lo, input logic [31:0] hi);
        send(lo);
        send(hi);
        model_push(lo, hi);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        int          prev_rec;

        vt[0] = '{32'h11,        32'h22,        1, 0};
        vt[1] = '{32'hA0,        32'hA1,        2, 0};
        vt[2] = '{32'hA0,        32'hA1,        2, 1};
        vt[3] = '{32'hB0,        32'hB1,        3, 1};
        vt[4] = '{32'hA0,        32'hA1,        4, 1};
        vt[5] = '{32'h0,         32'h0,         5, 1};
        vt[6] = '{32'h0,         32'h0,         5, 2};
        vt[7] = '{32'hFFFFFFFF,  32'h0,         6, 2};
        vt[8] = '{32'hFFFFFFFE,  32'hFFFFFFFF,  7, 2};

        rst = 1'b0; d_in = '0; d_in_valid = 1'b0; d_out_ready = 1'b1;
        s_in = '0; s_in_valid = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", d_out_valid, 0);
        check("rst_out",       d_out,       0);
        check("rst_out_last",  d_out_last,  0);
        check("rst_in_ready",  d_in_ready,  0);
        check("rst_rec_cnt",   d_rec,       0);
        check("rst_dup_cnt",   d_dup,       0);
        #10 rst = 1'b1;
        #1 check("ready_before_edge", d_in_ready, 0);
        @(posedge clk); #1;
        check("ready_after_edge", d_in_ready, 1);

        // Table: assembly, dedup and edge-valued records with out_ready=1
        for (int i = 0; i < 9; i++) begin
            send_rec(vt[i].lo, vt[i].hi);
            wait_cycles(3);
            check("tbl_rec_cnt",    d_rec, vt[i].exp_rec);
            check("tbl_dup_cnt",    d_dup, vt[i].exp_dup);
            check("tbl_valid_cycles", vcnt, vt[i].exp_rec);
        end

        // Backpressure: 8 records fill the FIFO, the 9th high half stalls
        d_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_rec(32'h100 + i, 32'h200 + i);
        send(32'h108);
        d_in = 32'h208; d_in_valid = 1'b1;
        @(negedge clk);
        check("bp_ready_full", d_in_ready, 0);
        held = d_out;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready_full", d_in_ready, 0);
            check("bp_out_hold",   d_out, held);
        end
        check("bp_head", d_out, {32'h200, 32'h100});
        @(posedge clk); #1;
        d_out_ready = 1'b1;
        send(32'h208);
        model_push(32'h108, 32'h208);
        wait_cycles(12);
        check("bp_drained", sb_q.size(), 0);
        check("bp_rec_cnt", d_rec, 16);

        // End of stream
        d_out_ready = 1'b0;
        send_rec(32'hA0, 32'hA1);
        send_rec(32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("eos_ready_done", d_in_ready, 0);
        end
        @(posedge clk); #1;
        d_out_ready = 1'b1;
        @(negedge clk);
        check("eos_ready_pop_a", d_in_ready, 0);
        check("eos_last_a",      d_out_last, 0);
        @(negedge clk);
        check("eos_ready_pop_m", d_in_ready, 0);
        check("eos_last_m",      d_out_last, 1);
        @(negedge clk);
        check("eos_ready_after", d_in_ready, 1);
        @(posedge clk); #1;
        prev_rec = int'(d_rec);
        send_rec(32'hA0, 32'hA1);
        wait_cycles(3);
        check("eos_repeat_pushed", d_rec, prev_rec + 1);
        check("eos_drained", sb_q.size(), 0);

        // Reset mid-record with a record pending in the FIFO
        d_out_ready = 1'b0;
        send_rec(32'h300, 32'h301);
        send(32'h55);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("mrst_out_valid", d_out_valid, 0);
        check("mrst_out",       d_out,       0);
        check("mrst_in_ready",  d_in_ready,  0);
        check("mrst_rec_cnt",   d_rec,       0);
        check("mrst_dup_cnt",   d_dup,       0);
        sb_q.delete();
        m_lastv = 0; m_rec = 0; m_dup = 0;
        #2 rst = 1'b1;
        d_out_ready = 1'b1;
        send_rec(32'h66, 32'h77);
        wait_cycles(3);
        check("mrst_new_rec", d_rec, 1);
        check("mrst_new_dup", d_dup, 0);
        check("mrst_drained", sb_q.size(), 0);

        // Counter saturation at CNT_W=4
        for (int i = 0; i < 40; i++) begin
            s_in       = (i % 2 == 0) ? 32'hC0 : 32'hC1;
            s_in_valid = 1'b1;
            @(negedge clk);
            check("sat_ready", s_in_ready, 1);
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        wait_cycles(3);
        check("sat_rec", s_rec, 1);
        check("sat_dup", s_dup, 15);
        wait_cycles(5);
        check("sat_rec_held", s_rec, 1);
        check("sat_dup_held", s_dup, 15);

        check("final_sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
